// File: rtl/cache_miss_arbiter_if.sv
// Signal bundle between the I/D cache miss ports, the arbiter and the shared miss handler.
// slave = arbiter side, master = everything around it (caches + handler).
interface cache_miss_arbiter_if #(
  parameter int BLKIDX_BIT = 4
);
  logic                  i_req;
  logic                  i_cached;
  logic                  i_w;
  logic [31:0]           i_paddr;
  logic [BLKIDX_BIT-1:0] i_blkidx;
  logic [31:0]           i_wdata;
  logic [3:0]            i_wen;
  logic                  i_fin;
  logic [31:0]           i_rdata;

  logic                  d_req;
  logic                  d_cached;
  logic                  d_w;
  logic [31:0]           d_paddr;
  logic [BLKIDX_BIT-1:0] d_blkidx;
  logic [31:0]           d_wdata;
  logic [3:0]            d_wen;
  logic                  d_fin;
  logic [31:0]           d_rdata;

  logic                  mh_req;
  logic                  mh_src;
  logic                  mh_cached;
  logic                  mh_w;
  logic [31:0]           mh_paddr;
  logic [BLKIDX_BIT-1:0] mh_blkidx;
  logic [31:0]           mh_wdata;
  logic [3:0]            mh_wen;
  logic                  mh_fin;
  logic [31:0]           mh_rdata;

  logic                  busy;

  modport slave (
    input  i_req, i_cached, i_w, i_paddr, i_blkidx, i_wdata, i_wen,
    output i_fin, i_rdata,
    input  d_req, d_cached, d_w, d_paddr, d_blkidx, d_wdata, d_wen,
    output d_fin, d_rdata,
    output mh_req, mh_src, mh_cached, mh_w, mh_paddr, mh_blkidx, mh_wdata, mh_wen,
    input  mh_fin, mh_rdata,
    output busy
  );

  modport master (
    output i_req, i_cached, i_w, i_paddr, i_blkidx, i_wdata, i_wen,
    input  i_fin, i_rdata,
    output d_req, d_cached, d_w, d_paddr, d_blkidx, d_wdata, d_wen,
    input  d_fin, d_rdata,
    input  mh_req, mh_src, mh_cached, mh_w, mh_paddr, mh_blkidx, mh_wdata, mh_wen,
    output mh_fin, mh_rdata,
    input  busy
  );
endinterface

// File: rtl/cache_miss_arbiter.sv
// Shares one miss handler between the I-cache and D-cache: grants one owner, freezes its
// command toward the handler until fin, routes fin back to the owner, swallows fin on flush.
module cache_miss_arbiter #(
  parameter int BLKIDX_BIT = 4,
  parameter bit FIXED_PRIO = 1'b0
) (
  input logic                  clk,
  input logic                  rst,
  cache_miss_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_I = 2'd1,
    OWN_D = 2'd2,
    DRAIN = 2'd3
  } state_t;

  typedef struct packed {
    logic                  cached;
    logic                  w;
    logic [31:0]           paddr;
    logic [BLKIDX_BIT-1:0] blkidx;
    logic [31:0]           wdata;
    logic [3:0]            wen;
  } cmd_t;

  state_t state, state_nx;
  cmd_t   cmd_q, i_cmd, d_cmd;
  logic   src_q;
  logic   last_grant_q;  // 0 = I-cache granted last, 1 = D-cache
  logic   grant;
  logic   grant_d;

  assign i_cmd = '{cached: bus.i_cached, w: bus.i_w, paddr: bus.i_paddr,
                   blkidx: bus.i_blkidx, wdata: bus.i_wdata, wen: bus.i_wen};
  assign d_cmd = '{cached: bus.d_cached, w: bus.d_w, paddr: bus.d_paddr,
                   blkidx: bus.d_blkidx, wdata: bus.d_wdata, wen: bus.d_wen};

  // NOTE: every output of this block gets a default before the case, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    grant_d  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.i_req || bus.d_req) begin
          grant    = 1'b1;
          // D wins a tie in fixed mode, or when I was the previous owner.
          grant_d  = bus.d_req && (!bus.i_req || FIXED_PRIO || !last_grant_q);
          state_nx = grant_d ? OWN_D : OWN_I;
        end
      end
      OWN_I: begin
        if (bus.mh_fin)      state_nx = IDLE;
        else if (!bus.i_req) state_nx = DRAIN;
      end
      OWN_D: begin
        if (bus.mh_fin)      state_nx = IDLE;
        else if (!bus.d_req) state_nx = DRAIN;
      end
      DRAIN: begin
        if (bus.mh_fin)      state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only, so every reader in this
  // time step sees the pre-edge value regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cmd_q        <= '0;
      src_q        <= 1'b0;
      last_grant_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (grant) begin
        cmd_q        <= grant_d ? d_cmd : i_cmd;
        src_q        <= grant_d;
        last_grant_q <= grant_d;
      end
    end
  end

  assign bus.mh_req    = (state != IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.mh_src    = src_q;
  assign bus.mh_cached = cmd_q.cached;
  assign bus.mh_w      = cmd_q.w;
  assign bus.mh_paddr  = cmd_q.paddr;
  assign bus.mh_blkidx = cmd_q.blkidx;
  assign bus.mh_wdata  = cmd_q.wdata;
  assign bus.mh_wen    = cmd_q.wen;

  // Fin in DRAIN (or IDLE) reaches neither cache.
  assign bus.i_fin   = bus.mh_fin && (state == OWN_I);
  assign bus.d_fin   = bus.mh_fin && (state == OWN_D);
  assign bus.i_rdata = bus.mh_rdata;
  assign bus.d_rdata = bus.mh_rdata;

endmodule

// File: tb/tb_cache_miss_arbiter.sv
// Directed bench for cache_miss_arbiter: a round-robin instance and a fixed-priority instance.
// Inputs change just after the falling edge; outputs are sampled 1 ns later.
module tb_cache_miss_arbiter;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  cache_miss_arbiter_if #(.BLKIDX_BIT(4)) bus ();
  cache_miss_arbiter_if #(.BLKIDX_BIT(4)) bus_fp ();

  cache_miss_arbiter #(.BLKIDX_BIT(4), .FIXED_PRIO(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  cache_miss_arbiter #(.BLKIDX_BIT(4), .FIXED_PRIO(1'b1)) dut_fp (
    .clk (clk),
    .rst (rst),
    .bus (bus_fp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic clear_inputs();
    bus.i_req = 0; bus.i_cached = 0; bus.i_w = 0; bus.i_paddr = 0; bus.i_blkidx = 0;
    bus.i_wdata = 0; bus.i_wen = 0;
    bus.d_req = 0; bus.d_cached = 0; bus.d_w = 0; bus.d_paddr = 0; bus.d_blkidx = 0;
    bus.d_wdata = 0; bus.d_wen = 0;
    bus.mh_fin = 0; bus.mh_rdata = 0;
    bus_fp.i_req = 0; bus_fp.i_cached = 0; bus_fp.i_w = 0; bus_fp.i_paddr = 0; bus_fp.i_blkidx = 0;
    bus_fp.i_wdata = 0; bus_fp.i_wen = 0;
    bus_fp.d_req = 0; bus_fp.d_cached = 0; bus_fp.d_w = 0; bus_fp.d_paddr = 0; bus_fp.d_blkidx = 0;
    bus_fp.d_wdata = 0; bus_fp.d_wen = 0;
    bus_fp.mh_fin = 0; bus_fp.mh_rdata = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    do_reset();
    #1;
    checks++; if ({bus.mh_req, bus.busy, bus.mh_src, bus.i_fin, bus.d_fin} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected %b", {bus.mh_req, bus.busy, bus.mh_src, bus.i_fin, bus.d_fin}, 5'b0); end
    checks++; if ({bus.mh_paddr, bus.mh_wdata} !== 64'h0) begin errors++; $display("FAIL reset_addr_data: got %h expected %h", {bus.mh_paddr, bus.mh_wdata}, 64'h0); end
    checks++; if ({bus.mh_cached, bus.mh_w, bus.mh_blkidx, bus.mh_wen} !== 10'h0) begin errors++; $display("FAIL reset_fields: got %h expected %h", {bus.mh_cached, bus.mh_w, bus.mh_blkidx, bus.mh_wen}, 10'h0); end
    checks++; if ({bus_fp.mh_req, bus_fp.busy, bus_fp.mh_src} !== 3'b0) begin errors++; $display("FAIL reset_fp_ctrl: got %b expected %b", {bus_fp.mh_req, bus_fp.busy, bus_fp.mh_src}, 3'b0); end
  endtask

  // I-only request to 0x1fc0_0040, handler finishes on the 8th owned cycle.
  task automatic test_single_i();
    int i_fins = 0;
    int d_fins = 0;
    @(negedge clk);
    bus.i_req = 1; bus.i_cached = 1; bus.i_paddr = 32'h1fc0_0040; bus.i_blkidx = 4'h3;
    #1;
    checks++; if (bus.mh_req !== 1'b0) begin errors++; $display("FAIL single_grant_latency: got %b expected %b", bus.mh_req, 1'b0); end
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 8) bus.mh_fin = 1;
      #1;
      if (bus.i_fin === 1'b1) i_fins++;
      if (bus.d_fin === 1'b1) d_fins++;
      checks++; if ({bus.mh_req, bus.mh_src} !== 2'b10) begin errors++; $display("FAIL single_req_src c%0d: got %b expected %b", c, {bus.mh_req, bus.mh_src}, 2'b10); end
      checks++; if (bus.mh_paddr !== 32'h1fc0_0040) begin errors++; $display("FAIL single_paddr c%0d: got %h expected %h", c, bus.mh_paddr, 32'h1fc0_0040); end
    end
    checks++; if ({bus.mh_cached, bus.mh_blkidx} !== 5'h13) begin errors++; $display("FAIL single_fields: got %h expected %h", {bus.mh_cached, bus.mh_blkidx}, 5'h13); end
    @(negedge clk);
    bus.mh_fin = 0; bus.i_req = 0;
    #1;
    if (bus.i_fin === 1'b1) i_fins++;
    checks++; if ({bus.mh_req, bus.busy} !== 2'b00) begin errors++; $display("FAIL single_idle: got %b expected %b", {bus.mh_req, bus.busy}, 2'b00); end
    checks++; if (i_fins !== 1) begin errors++; $display("FAIL single_i_fin_count: got %0d expected %0d", i_fins, 1); end
    checks++; if (d_fins !== 0) begin errors++; $display("FAIL single_d_fin_count: got %0d expected %0d", d_fins, 0); end
  endtask

  // Both held from reset: D, I, D, I with one IDLE cycle between owners.
  task automatic test_rr_alternation();
    logic exp_src;
    do_reset();
    @(negedge clk);
    bus.i_req = 1; bus.i_paddr = 32'h0000_0100;
    bus.d_req = 1; bus.d_paddr = 32'h0000_0200;
    #1;
    checks++; if (bus.mh_req !== 1'b0) begin errors++; $display("FAIL rr_grant_latency: got %b expected %b", bus.mh_req, 1'b0); end
    for (int k = 0; k < 4; k++) begin
      exp_src = (k % 2 == 0);
      @(negedge clk);
      #1;
      checks++; if ({bus.mh_req, bus.mh_src} !== {1'b1, exp_src}) begin errors++; $display("FAIL rr_owner k%0d: got %b expected %b", k, {bus.mh_req, bus.mh_src}, {1'b1, exp_src}); end
      checks++; if (bus.mh_paddr !== (exp_src ? 32'h200 : 32'h100)) begin errors++; $display("FAIL rr_paddr k%0d: got %h expected %h", k, bus.mh_paddr, (exp_src ? 32'h200 : 32'h100)); end
      bus.mh_fin = 1;
      #1;
      checks++; if ({bus.i_fin, bus.d_fin} !== (exp_src ? 2'b01 : 2'b10)) begin errors++; $display("FAIL rr_fin k%0d: got %b expected %b", k, {bus.i_fin, bus.d_fin}, (exp_src ? 2'b01 : 2'b10)); end
      @(negedge clk);
      bus.mh_fin = 0;
      #1;
      checks++; if ({bus.mh_req, bus.busy} !== 2'b00) begin errors++; $display("FAIL rr_idle_gap k%0d: got %b expected %b", k, {bus.mh_req, bus.busy}, 2'b00); end
      if (k == 3) begin bus.i_req = 0; bus.d_req = 0; end
    end
  endtask

  // Fixed priority: D wins every tie; I only served once d_req is low.
  task automatic test_fixed_prio();
    @(negedge clk);
    bus_fp.i_req = 1; bus_fp.i_paddr = 32'h0000_0a00;
    bus_fp.d_req = 1; bus_fp.d_paddr = 32'h0000_0b00;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      checks++; if ({bus_fp.mh_req, bus_fp.mh_src} !== 2'b11) begin errors++; $display("FAIL fp_owner_d k%0d: got %b expected %b", k, {bus_fp.mh_req, bus_fp.mh_src}, 2'b11); end
      bus_fp.mh_fin = 1;
      #1;
      checks++; if ({bus_fp.i_fin, bus_fp.d_fin} !== 2'b01) begin errors++; $display("FAIL fp_fin_d k%0d: got %b expected %b", k, {bus_fp.i_fin, bus_fp.d_fin}, 2'b01); end
      @(negedge clk);
      bus_fp.mh_fin = 0;
      if (k == 2) bus_fp.d_req = 0;
    end
    @(negedge clk);
    #1;
    checks++; if ({bus_fp.mh_req, bus_fp.mh_src, bus_fp.mh_paddr} !== {2'b10, 32'h0a00}) begin errors++; $display("FAIL fp_owner_i: got %h expected %h", {bus_fp.mh_req, bus_fp.mh_src, bus_fp.mh_paddr}, {2'b10, 32'h0a00}); end
    bus_fp.mh_fin = 1;
    #1;
    checks++; if ({bus_fp.i_fin, bus_fp.d_fin} !== 2'b10) begin errors++; $display("FAIL fp_fin_i: got %b expected %b", {bus_fp.i_fin, bus_fp.d_fin}, 2'b10); end
    @(negedge clk);
    bus_fp.mh_fin = 0; bus_fp.i_req = 0;
    #1;
    checks++; if (bus_fp.busy !== 1'b0) begin errors++; $display("FAIL fp_idle: got %b expected %b", bus_fp.busy, 1'b0); end
  endtask

  // D owner flushes at cycle 3, handler fins at cycle 6 and is swallowed; pending I follows.
  task automatic test_drain();
    @(negedge clk);
    bus.d_req = 1; bus.d_paddr = 32'h0000_0300;
    @(negedge clk);
    bus.i_req = 1; bus.i_paddr = 32'h0000_0400;
    #1;
    checks++; if ({bus.mh_req, bus.mh_src} !== 2'b11) begin errors++; $display("FAIL drain_owner_d: got %b expected %b", {bus.mh_req, bus.mh_src}, 2'b11); end
    @(negedge clk);
    @(negedge clk);
    bus.d_req = 0;
    for (int n = 4; n <= 6; n++) begin
      @(negedge clk);
      if (n == 6) bus.mh_fin = 1;
      #1;
      checks++; if ({bus.mh_req, bus.busy, bus.mh_src} !== 3'b111) begin errors++; $display("FAIL drain_hold n%0d: got %b expected %b", n, {bus.mh_req, bus.busy, bus.mh_src}, 3'b111); end
      checks++; if ({bus.i_fin, bus.d_fin} !== 2'b00) begin errors++; $display("FAIL drain_no_fin n%0d: got %b expected %b", n, {bus.i_fin, bus.d_fin}, 2'b00); end
    end
    checks++; if (bus.mh_paddr !== 32'h300) begin errors++; $display("FAIL drain_paddr: got %h expected %h", bus.mh_paddr, 32'h300); end
    @(negedge clk);
    bus.mh_fin = 0;
    #1;
    checks++; if ({bus.mh_req, bus.busy} !== 2'b00) begin errors++; $display("FAIL drain_idle: got %b expected %b", {bus.mh_req, bus.busy}, 2'b00); end
    @(negedge clk);
    #1;
    checks++; if ({bus.mh_req, bus.mh_src, bus.mh_paddr} !== {2'b10, 32'h400}) begin errors++; $display("FAIL drain_next_i: got %h expected %h", {bus.mh_req, bus.mh_src, bus.mh_paddr}, {2'b10, 32'h400}); end
    bus.mh_fin = 1;
    #1;
    checks++; if ({bus.i_fin, bus.d_fin} !== 2'b10) begin errors++; $display("FAIL drain_next_fin: got %b expected %b", {bus.i_fin, bus.d_fin}, 2'b10); end
    @(negedge clk);
    bus.mh_fin = 0; bus.i_req = 0;
  endtask

  // Command frozen against requester changes; uncached read data passes straight through.
  task automatic test_freeze_rdata();
    @(negedge clk);
    bus.i_req = 1; bus.i_cached = 0; bus.i_w = 1; bus.i_paddr = 32'h0000_1234;
    bus.i_wdata = 32'h1111_2222; bus.i_wen = 4'h6; bus.i_blkidx = 4'h5;
    @(negedge clk);
    bus.i_paddr = 32'hffff_0000; bus.i_wdata = 32'h0; bus.i_blkidx = 4'ha; bus.i_w = 0; bus.i_wen = 4'h0;
    #1;
    checks++; if ({bus.mh_cached, bus.mh_w, bus.mh_blkidx, bus.mh_wen} !== 10'b0_1_0101_0110) begin errors++; $display("FAIL freeze_fields: got %b expected %b", {bus.mh_cached, bus.mh_w, bus.mh_blkidx, bus.mh_wen}, 10'b0_1_0101_0110); end
    @(negedge clk);
    #1;
    checks++; if ({bus.mh_paddr, bus.mh_wdata} !== {32'h0000_1234, 32'h1111_2222}) begin errors++; $display("FAIL freeze_addr_data: got %h expected %h", {bus.mh_paddr, bus.mh_wdata}, {32'h0000_1234, 32'h1111_2222}); end
    bus.mh_rdata = 32'hdead_beef; bus.mh_fin = 1;
    #1;
    checks++; if ({bus.i_fin, bus.i_rdata} !== {1'b1, 32'hdead_beef}) begin errors++; $display("FAIL rdata_i: got %h expected %h", {bus.i_fin, bus.i_rdata}, {1'b1, 32'hdead_beef}); end
    checks++; if ({bus.d_fin, bus.d_rdata} !== {1'b0, 32'hdead_beef}) begin errors++; $display("FAIL rdata_d: got %h expected %h", {bus.d_fin, bus.d_rdata}, {1'b0, 32'hdead_beef}); end
    @(negedge clk);
    bus.mh_fin = 0; bus.i_req = 0; bus.mh_rdata = 0;
  endtask

  // Flush and fin in the same cycle: fin wins and the arbiter returns to IDLE, not DRAIN.
  task automatic test_fin_vs_flush();
    @(negedge clk);
    bus.i_req = 1; bus.i_paddr = 32'h0000_0600;
    @(negedge clk);
    bus.i_req = 0; bus.mh_fin = 1;
    #1;
    checks++; if ({bus.i_fin, bus.d_fin} !== 2'b10) begin errors++; $display("FAIL finflush_fin: got %b expected %b", {bus.i_fin, bus.d_fin}, 2'b10); end
    @(negedge clk);
    bus.mh_fin = 0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL finflush_idle: got %b expected %b", bus.busy, 1'b0); end
  endtask

  task automatic test_idle_fin();
    @(negedge clk);
    bus.mh_fin = 1;
    #1;
    checks++; if ({bus.i_fin, bus.d_fin} !== 2'b00) begin errors++; $display("FAIL idlefin_fins: got %b expected %b", {bus.i_fin, bus.d_fin}, 2'b00); end
    @(negedge clk);
    bus.mh_fin = 0;
    #1;
    checks++; if ({bus.mh_req, bus.busy} !== 2'b00) begin errors++; $display("FAIL idlefin_state: got %b expected %b", {bus.mh_req, bus.busy}, 2'b00); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.d_req = 1; bus.d_cached = 1; bus.d_paddr = 32'h0000_0500; bus.d_wdata = 32'h0000_abcd;
    bus.d_blkidx = 4'h7; bus.d_wen = 4'hf;
    @(negedge clk);
    #1;
    checks++; if ({bus.mh_req, bus.mh_src, bus.mh_paddr} !== {2'b11, 32'h500}) begin errors++; $display("FAIL rstmid_owner: got %h expected %h", {bus.mh_req, bus.mh_src, bus.mh_paddr}, {2'b11, 32'h500}); end
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++; if ({bus.mh_req, bus.busy, bus.mh_src, bus.i_fin, bus.d_fin} !== 5'b0) begin errors++; $display("FAIL rstmid_ctrl: got %b expected %b", {bus.mh_req, bus.busy, bus.mh_src, bus.i_fin, bus.d_fin}, 5'b0); end
    checks++; if ({bus.mh_cached, bus.mh_w, bus.mh_paddr, bus.mh_blkidx, bus.mh_wdata, bus.mh_wen} !== 74'h0) begin errors++; $display("FAIL rstmid_fields: got %h expected %h", {bus.mh_cached, bus.mh_w, bus.mh_paddr, bus.mh_blkidx, bus.mh_wdata, bus.mh_wen}, 74'h0); end
    rst = 1'b0;
    bus.d_req = 0;
    @(negedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_after: got %b expected %b", bus.busy, 1'b0); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single_i();
    test_rr_alternation();
    test_fixed_prio();
    test_drain();
    test_freeze_rdata();
    test_fin_vs_flush();
    test_idle_fin();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
